// File: rtl/hook_line_ctrl.sv
// -----------------------------------------------------------------------------
// hook_line_ctrl
//   Frame-rate sequencer for the fishing hook. It produces the hook depth
//   (hook_v) and the sprite mode that the bait/hook renderer draws. The block
//   sequences cast, mouse-tracked descent, reel-in, fish-hooked and the
//   catch/escape events. All hook motion happens on frame_tick. State
//   transitions are evaluated on every clock.
//
//   Optional feature: define HOOK_LINE_ESCAPE_EN to let a hooked fish escape
//   after ESCAPE_FRAMES frames without reeling. When the macro is undefined,
//   escape_pulse stays 0 and a hooked fish never escapes.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   frame_tick    one-cycle pulse per video frame
//   cast          one-cycle cast request (ignored outside IDLE)
//   reel          level, reel button held
//   bite          one-cycle pulse, fish touched the hook
//   bait_avail    level, player holds bait at cast time
//   mouse_y[9:0]  target depth for tracking
//   hook_v[9:0]   hook top row (registered)
//   mode[1:0]     0 none, 1 hook, 2 hook+bait, 3 hook+fish (registered)
//   busy          state != IDLE
//   bait_used     one-cycle pulse when a bite is accepted
//   catch_pulse   one-cycle pulse when a hooked fish reaches TOP_V
//   escape_pulse  one-cycle pulse when a hooked fish escapes
//   state_dbg     FSM state: 0 IDLE, 1 TRACK, 2 REEL, 3 HOOKED
//
// Handshake: there is no valid/ready flow. Every input is sampled on each
//   rising clock edge. Motion inputs only act in a cycle where frame_tick=1.
//   Every output is a register.
// -----------------------------------------------------------------------------
module hook_line_ctrl #(
    parameter int TOP_V         = 62,
    parameter int BOT_V         = 465,
    parameter int TRACK_STEP    = 4,
    parameter int REEL_STEP     = 6,
    parameter int HOOK_STEP     = 2,
    parameter int ESCAPE_FRAMES = 90
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       cast,
    input  logic       reel,
    input  logic       bite,
    input  logic       bait_avail,
    input  logic [9:0] mouse_y,
    output logic [9:0] hook_v,
    output logic [1:0] mode,
    output logic       busy,
    output logic       bait_used,
    output logic       catch_pulse,
    output logic       escape_pulse,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_REEL   = 2'd2,
        S_HOOKED = 2'd3
    } state_t;

    localparam logic signed [10:0] TOP_S   = 11'(TOP_V);
    localparam logic signed [10:0] BOT_S   = 11'(BOT_V);
    localparam logic signed [10:0] TRK_S   = 11'(TRACK_STEP);
    localparam logic signed [10:0] REEL_S  = 11'(REEL_STEP);
    localparam logic signed [10:0] HOOK_S  = 11'(HOOK_STEP);

    state_t      state, state_n;
    logic [9:0]  hook_n;
    logic [1:0]  mode_n;
    logic        bait_used_n, catch_n, escape_n;
    logic        bite_ok;

    // Signed 11-bit intermediates. A 10-bit value minus a step can go below
    // zero without wrapping.
    logic signed [10:0] hook_s, mouse_s, tgt, diff;
    logic signed [10:0] track_s, reel_s, hooked_s;

`ifdef HOOK_LINE_ESCAPE_EN
    logic [7:0] esc_cnt, esc_cnt_n;
`endif

    // Candidate next depths for each motion type.
    always_comb begin
        hook_s  = signed'({1'b0, hook_v});
        mouse_s = signed'({1'b0, mouse_y});
        tgt     = mouse_s;
        if (mouse_s < TOP_S) tgt = TOP_S;
        if (mouse_s > BOT_S) tgt = BOT_S;
        diff    = tgt - hook_s;
        if (diff > TRK_S)       track_s = hook_s + TRK_S;
        else if (diff < -TRK_S) track_s = hook_s - TRK_S;
        else                    track_s = tgt;
        reel_s   = hook_s - REEL_S;
        if (reel_s < TOP_S) reel_s = TOP_S;
        hooked_s = hook_s - HOOK_S;
        if (hooked_s < TOP_S) hooked_s = TOP_S;
    end

    assign bite_ok = bite && (mode == 2'd2);

    always_comb begin
        state_n     = state;
        hook_n      = hook_v;
        mode_n      = mode;
        bait_used_n = 1'b0;
        catch_n     = 1'b0;
        escape_n    = 1'b0;
`ifdef HOOK_LINE_ESCAPE_EN
        esc_cnt_n   = esc_cnt;
`endif
        case (state)
            S_IDLE: begin
                hook_n = 10'(TOP_V);
                mode_n = 2'd0;
                if (cast) begin
                    state_n = S_TRACK;
                    mode_n  = bait_avail ? 2'd2 : 2'd1;
                end
            end
            S_TRACK: begin
                if (frame_tick) hook_n = track_s[9:0];
                if (bite_ok) begin
                    state_n     = S_HOOKED;
                    mode_n      = 2'd3;
                    bait_used_n = 1'b1;
`ifdef HOOK_LINE_ESCAPE_EN
                    esc_cnt_n   = 8'd0;
`endif
                end else if (reel) begin
                    state_n = S_REEL;
                end
            end
            S_REEL: begin
                if (frame_tick) hook_n = reel_s[9:0];
                // Bite outranks the surface check and the reel release.
                if (bite_ok) begin
                    state_n     = S_HOOKED;
                    mode_n      = 2'd3;
                    bait_used_n = 1'b1;
`ifdef HOOK_LINE_ESCAPE_EN
                    esc_cnt_n   = 8'd0;
`endif
                end else if (hook_v == 10'(TOP_V)) begin
                    state_n = S_IDLE;
                    mode_n  = 2'd0;
                end else if (!reel) begin
                    state_n = S_TRACK;
                end
            end
            S_HOOKED: begin
                if (frame_tick && reel) hook_n = hooked_s[9:0];
                // Reaching the surface outranks an escape in the same cycle.
                if (hook_v == 10'(TOP_V)) begin
                    state_n = S_IDLE;
                    mode_n  = 2'd0;
                    catch_n = 1'b1;
                end
`ifdef HOOK_LINE_ESCAPE_EN
                else if (frame_tick) begin
                    if (reel) begin
                        esc_cnt_n = 8'd0;
                    end else if (esc_cnt == 8'(ESCAPE_FRAMES - 1)) begin
                        esc_cnt_n = 8'd0;
                        escape_n  = 1'b1;
                        state_n   = S_TRACK;
                        mode_n    = 2'd1;
                    end else begin
                        esc_cnt_n = esc_cnt + 8'd1;
                    end
                end
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            hook_v       <= 10'(TOP_V);
            mode         <= 2'd0;
            bait_used    <= 1'b0;
            catch_pulse  <= 1'b0;
            escape_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            hook_v       <= hook_n;
            mode         <= mode_n;
            bait_used    <= bait_used_n;
            catch_pulse  <= catch_n;
            escape_pulse <= escape_n;
        end
    end

`ifdef HOOK_LINE_ESCAPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) esc_cnt <= 8'd0;
        else        esc_cnt <= esc_cnt_n;
    end
`endif

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_hook_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hook_line_ctrl
//   Directed scenarios with hand-computed expectations, followed by random
//   stimulus. A frame-level reference model steps once per clock. One compare
//   process checks every output against the model in every cycle outside reset.
// -----------------------------------------------------------------------------
module tb_hook_line_ctrl;

    localparam int TOP = 62;
    localparam int BOT = 465;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, cast = 1'b0, reel = 1'b0, bite = 1'b0;
    logic       bait_avail = 1'b0;
    logic [9:0] mouse_y = 10'd0;
    logic [9:0] hook_v;
    logic [1:0] mode, state_dbg;
    logic       busy, bait_used, catch_pulse, escape_pulse;

    always #5 clk = ~clk;

    hook_line_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .cast(cast),
        .reel(reel), .bite(bite), .bait_avail(bait_avail), .mouse_y(mouse_y),
        .hook_v(hook_v), .mode(mode), .busy(busy), .bait_used(bait_used),
        .catch_pulse(catch_pulse), .escape_pulse(escape_pulse),
        .state_dbg(state_dbg)
    );

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase of play: 0 idle, 1 tracking, 2 reeling, 3 fish on.
    int m_phase = 0, m_hook = TOP, m_mode = 0, m_frames = 0;
    int m_bu = 0, m_cp = 0, m_ep = 0;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_step();
        int nh, np, nm, nf, tgt;
        nh = m_hook; np = m_phase; nm = m_mode; nf = m_frames;
        m_bu = 0; m_cp = 0; m_ep = 0;
        if (m_phase == 0) begin
            nh = TOP; nm = 0;
            if (cast) begin np = 1; nm = bait_avail ? 2 : 1; end
        end else if (m_phase == 3) begin
            if (frame_tick && reel) nh = clampi(m_hook - 2, TOP, BOT);
            if (m_hook == TOP) begin
                np = 0; nm = 0; m_cp = 1;
            end else if (frame_tick) begin
                nf = reel ? 0 : m_frames + 1;
`ifdef HOOK_LINE_ESCAPE_EN
                if (nf >= 90) begin nf = 0; m_ep = 1; np = 1; nm = 1; end
`endif
            end
        end else begin
            if (frame_tick) begin
                if (m_phase == 1) begin
                    tgt = clampi(int'(mouse_y), TOP, BOT);
                    nh  = clampi(tgt, m_hook - 4, m_hook + 4);
                end else begin
                    nh = clampi(m_hook - 6, TOP, BOT);
                end
            end
            if (bite && m_mode == 2) begin
                np = 3; nm = 3; m_bu = 1; nf = 0;
            end else if (m_phase == 2 && m_hook == TOP) begin
                np = 0; nm = 0;
            end else begin
                np = reel ? 2 : 1;
            end
        end
        m_hook = nh; m_phase = np; m_mode = nm; m_frames = nf;
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_hook = TOP; m_mode = 0; m_frames = 0;
            m_bu = 0; m_cp = 0; m_ep = 0;
        end else begin
            model_step();
        end
        #2;
        if (rst_n) begin
            check("m_hook_v", int'(hook_v), m_hook);
            check("m_mode", int'(mode), m_mode);
            check("m_state", int'(state_dbg), m_phase);
            check("m_busy", int'(busy), int'(m_phase != 0));
            check("m_bait_used", int'(bait_used), m_bu);
            check("m_catch", int'(catch_pulse), m_cp);
            check("m_escape", int'(escape_pulse), m_ep);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_cast(input logic with_bait);
        @(negedge clk); cast = 1'b1; bait_avail = with_bait;
        @(negedge clk); cast = 1'b0;
    endtask

    task automatic pulse_bite();
        @(negedge clk); bite = 1'b1;
        @(negedge clk); bite = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cycles(3);
        check("rst_hook", int'(hook_v), 62);
        check("rst_mode", int'(mode), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        cycles(2);

        // Cast with bait and track down to row 100.
        mouse_y = 10'd100;
        do_cast(1'b1);
        check("cast_mode", int'(mode), 2);
        check("cast_hook", int'(hook_v), 62);
        exp_q = '{10'd66, 10'd70, 10'd74, 10'd78, 10'd82,
                  10'd86, 10'd90, 10'd94, 10'd98, 10'd100};
        for (int i = 0; i < 10; i++) begin
            tick();
            check("track100", int'(hook_v), int'(exp_q.pop_front()));
        end

        // Bite and reel in the same cycle: the bite wins. Then land the fish.
        @(negedge clk); bite = 1'b1; reel = 1'b1;
        @(negedge clk); bite = 1'b0;
        check("hooked_mode", int'(mode), 3);
        check("hooked_state", int'(state_dbg), 3);
        check("bait_used_hi", int'(bait_used), 1);
        @(negedge clk);
        check("bait_used_lo", int'(bait_used), 0);
        ticks(19);
        check("land_hook", int'(hook_v), 62);
        check("catch_early", int'(catch_pulse), 0);
        @(negedge clk);
        check("catch_hi", int'(catch_pulse), 1);
        check("catch_busy", int'(busy), 0);
        check("catch_mode", int'(mode), 0);
        @(negedge clk);
        check("catch_lo", int'(catch_pulse), 0);
        reel = 1'b0;

        // Bare hook, with clamping at both depth limits.
        mouse_y = 10'd300;
        do_cast(1'b0);
        check("bare_mode", int'(mode), 1);
        ticks(60);
        check("track300", int'(hook_v), 300);
        mouse_y = 10'd1000;
        ticks(50);
        check("clamp_bot", int'(hook_v), 465);
        mouse_y = 10'd0;
        ticks(110);
        check("clamp_top", int'(hook_v), 62);
        check("top_stays_track", int'(state_dbg), 1);

        // A bite on a bare hook is ignored. Then reel up to the surface.
        mouse_y = 10'd150;
        ticks(25);
        check("track150", int'(hook_v), 150);
        pulse_bite();
        check("bare_bite_mode", int'(mode), 1);
        check("bare_bite_used", int'(bait_used), 0);
        @(negedge clk); reel = 1'b1;
        @(negedge clk);
        check("reel_state", int'(state_dbg), 2);
        tick(); check("reel_144", int'(hook_v), 144);
        tick(); check("reel_138", int'(hook_v), 138);
        ticks(13);
        check("reel_top", int'(hook_v), 62);
        @(negedge clk);
        check("reel_idle", int'(busy), 0);
        reel = 1'b0;

        // Asynchronous reset in the middle of reeling, at row 200.
        mouse_y = 10'd200;
        do_cast(1'b1);
        ticks(40);
        check("track200", int'(hook_v), 200);
        @(negedge clk); reel = 1'b1;
        @(negedge clk);
        check("reel200_state", int'(state_dbg), 2);
        rst_n = 1'b0;
        #1;
        check("arst_hook", int'(hook_v), 62);
        check("arst_mode", int'(mode), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_pulses", int'({bait_used, catch_pulse, escape_pulse}), 0);
        reel = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Fish on, no reeling.
        mouse_y = 10'd150;
        do_cast(1'b1);
        ticks(25);
        pulse_bite();
        check("esc_hooked", int'(mode), 3);
`ifdef HOOK_LINE_ESCAPE_EN
        ticks(89);
        check("esc_89_none", int'(escape_pulse), 0);
        @(negedge clk); reel = 1'b1;
        tick();
        reel = 1'b0;
        check("esc_reel_hook", int'(hook_v), 148);
        ticks(89);
        check("esc_reset_none", int'(escape_pulse), 0);
        check("esc_still_hooked", int'(state_dbg), 3);
        tick();
        check("esc_pulse", int'(escape_pulse), 1);
        check("esc_mode", int'(mode), 1);
        check("esc_state", int'(state_dbg), 1);
        @(negedge clk);
        check("esc_pulse_lo", int'(escape_pulse), 0);
`else
        ticks(120);
        check("noesc_state", int'(state_dbg), 3);
        check("noesc_mode", int'(mode), 3);
        check("noesc_pulse", int'(escape_pulse), 0);
`endif
        reel = 1'b1;
        ticks(50);
        reel = 1'b0;
        cycles(3);
        check("cleanup_idle", int'(busy), 0);

        // Random play: first with a busy reel button, then with the reel mostly idle.
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst_n      = ($urandom_range(0, 1499) != 0);
            frame_tick = ($urandom_range(0, 3) == 0);
            cast       = ($urandom_range(0, 15) == 0);
            bite       = ($urandom_range(0, 19) == 0);
            bait_avail = 1'($urandom_range(0, 1));
            if (i < 3000) begin
                if ($urandom_range(0, 15) == 0) reel = ~reel;
            end else begin
                reel = ($urandom_range(0, 299) == 0);
            end
            if ($urandom_range(0, 7) == 0) mouse_y = 10'($urandom_range(0, 1023));
        end
        @(negedge clk);
        rst_n = 1'b1; frame_tick = 1'b0; cast = 1'b0; bite = 1'b0; reel = 1'b0;
        cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
